// File: rtl/keypad_decoder.sv
// rtl/keypad_decoder.sv - 4x4 matrix keypad scanner, row debounce, one-cycle key code pulse
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_decoder #(
  parameter int SCAN_TICKS     = 20000,
  parameter int DEBOUNCE_TICKS = 200000,
  parameter int REPEAT_TICKS   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] key_coord,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_TICKS);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_CONFIRM,
    ST_HOLD
  } state_t;

  logic [3:0]    row_meta_q;
  logic [3:0]    row_s_q;
  state_t        state_q;
  logic [SW-1:0] tick_q;
  logic [DW-1:0] deb_q;
  logic [3:0]    row_cap_q;
  logic [3:0]    col_q;
  logic [7:0]    key_coord_q;
  logic          key_held_q;
  logic          one_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_q;
`else
  localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif

  assign col_out   = col_q;
  assign key_coord = key_coord_q;
  assign key_held  = key_held_q;

  // Two-flop synchronizer for the asynchronous rows; idle level is all-high
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_s_q    <= row_meta_q;
    end
  end

  // Exactly one low row means a single unambiguous key in the driven column
  always_comb begin
    case (row_s_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  end

  // Scan / confirm / hold sequencing with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      tick_q      <= '0;
      deb_q       <= '0;
      row_cap_q   <= 4'hF;
      col_q       <= 4'b1110;
      key_coord_q <= 8'h00;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      // The code is a one-cycle pulse; every other cycle reads zero
      key_coord_q <= 8'h00;
      case (state_q)
        ST_SCAN: begin
          // Rows are only trusted at the end of the dwell, after settling and sync
          if (tick_q == SCAN_LAST) begin
            tick_q <= '0;
            if (one_low) begin
              row_cap_q <= row_s_q;
              deb_q     <= '0;
              state_q   <= ST_CONFIRM;
            end else begin
              col_q <= {col_q[2:0], col_q[3]};
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (row_s_q != row_cap_q) begin
            // Bounce: rescan the same column from a fresh dwell
            state_q <= ST_SCAN;
            tick_q  <= '0;
            deb_q   <= '0;
          end else if (deb_q == DEB_LAST) begin
            key_coord_q <= {row_cap_q, col_q};
            key_held_q  <= 1'b1;
            deb_q       <= '0;
            state_q     <= ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        ST_HOLD: begin
          // deb_q now counts consecutive all-released cycles
          if (row_s_q == 4'hF) begin
            if (deb_q == DEB_LAST) begin
              key_held_q <= 1'b0;
              deb_q      <= '0;
              col_q      <= 4'b1110;
              tick_q     <= '0;
              state_q    <= ST_SCAN;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end else begin
            deb_q <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (row_s_q == row_cap_q) begin
            if (rep_q == REP_LAST) begin
              rep_q       <= '0;
              key_coord_q <= {row_cap_q, col_q};
            end else begin
              rep_q <= rep_q + 1'b1;
            end
          end else begin
            rep_q <= '0;
          end
`endif
        end
        default: begin
          state_q <= ST_SCAN;
          tick_q  <= '0;
          deb_q   <= '0;
          col_q   <= 4'b1110;
        end
      endcase
    end
  end

endmodule
